// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC / fetch-control stage: FSM state encoding,
// default instruction-memory size and the fetch-fault predicate.
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LOAD    = 2'd1,
        ST_RESTART = 2'd2,
        ST_HALT    = 2'd3
    } fetch_state_e;

    // Default instruction memory: 64 words of 32 bits.
    localparam int unsigned IMEM_BYTES = 64 * 4;

    // A fetch target is bad if it is not word aligned or lies past the end
    // of instruction memory.
    function automatic logic addr_fault(input logic [31:0] addr,
                                        input logic [31:0] limit);
        return (addr[1:0] != 2'b00) || (addr >= limit);
    endfunction

endpackage

// File: rtl/pc_fetch_unit_next_mux.sv
// Next-PC select: sequential PC+4 or branch Result, plus a fault flag when
// the chosen target cannot be fetched (misaligned or out of range).
module pc_next_mux
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES)
) (
    input  logic        pcsrc_i,
    input  logic [31:0] pc_plus4_i,
    input  logic [31:0] result_i,
    output logic [31:0] next_pc_o,
    output logic        fault_o
);

    // Branch target wins over sequential; the fault check covers whichever was picked.
    always_comb begin
        next_pc_o = pcsrc_i ? result_i : pc_plus4_i;
        fault_o   = addr_fault(next_pc_o, IMEM_LIMIT);
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch control. Advances or branches the PC, runs the
// keyboard-reload sequence (LOAD writes the latched code, RESTART rewinds
// the PC) and halts on an unfetchable target until reset or a reload.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0,
    parameter int unsigned IMEM_WORDS   = IMEM_BYTES / 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        Stall,
    input  logic        PCSrc,
    input  logic [31:0] Result,
    input  logic        kbd_load,
    input  logic [5:0]  kbd_in,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic [31:0] PCPlus8,
    output logic        imem_we,
    output logic [5:0]  kbd_code,
    output logic        fetch_valid,
    output logic        halted
);

    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS * 4);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [5:0]   kbd_code_q, kbd_code_d;
    logic         kbd_load_q;
    logic         imem_we_q, fetch_valid_q, halted_q;

    logic         kbd_rise;
    logic [31:0]  nxt_pc;
    logic         nxt_fault;

    assign PCPlus4  = pc_q + 32'd4;
    assign PCPlus8  = pc_q + 32'd8;
    assign kbd_rise = kbd_load & ~kbd_load_q;

    pc_next_mux #(
        .IMEM_LIMIT (IMEM_LIMIT)
    ) u_next_mux (
        .pcsrc_i    (PCSrc),
        .pc_plus4_i (PCPlus4),
        .result_i   (Result),
        .next_pc_o  (nxt_pc),
        .fault_o    (nxt_fault)
    );

    // Next state: reload request beats stall, stall beats branch/sequential.
    // A fault leaves the PC on the last good address.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        kbd_code_d = kbd_code_q;
        case (state_q)
            ST_RUN: begin
                if (kbd_rise) begin
                    state_d    = ST_LOAD;
                    kbd_code_d = kbd_in;
                end else if (!Stall) begin
                    if (nxt_fault) state_d = ST_HALT;
                    else           pc_d    = nxt_pc;
                end
            end
            ST_LOAD:    state_d = ST_RESTART;
            ST_RESTART: begin
                pc_d    = RESET_VECTOR;
                state_d = ST_RUN;
            end
            ST_HALT: begin
                if (kbd_rise) begin
                    state_d    = ST_LOAD;
                    kbd_code_d = kbd_in;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State, PC and code registers; the status outputs are registered copies
    // of the state decode so they never follow same-cycle inputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_VECTOR;
            kbd_code_q    <= 6'd0;
            kbd_load_q    <= 1'b0;
            imem_we_q     <= 1'b0;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            kbd_code_q    <= kbd_code_d;
            kbd_load_q    <= kbd_load;
            imem_we_q     <= (state_d == ST_LOAD);
            fetch_valid_q <= (state_d == ST_RUN);
            halted_q      <= (state_d == ST_HALT);
        end
    end

    assign PC          = pc_q;
    assign kbd_code    = kbd_code_q;
    assign imem_we     = imem_we_q;
    assign fetch_valid = fetch_valid_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: stimulus pushes the hand-computed
// expected outputs tagged with the negedge at which they must hold; the
// monitor samples every negedge and compares against due entries.
module tb_pc_fetch_unit;

    logic        CLK;
    logic        RESET;
    logic        Stall;
    logic        PCSrc;
    logic [31:0] Result;
    logic        kbd_load;
    logic [5:0]  kbd_in;
    logic [31:0] PC, PCPlus4, PCPlus8;
    logic        imem_we;
    logic [5:0]  kbd_code;
    logic        fetch_valid;
    logic        halted;

    pc_fetch_unit #(
        .RESET_VECTOR (32'h0),
        .IMEM_WORDS   (64)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .Stall       (Stall),
        .PCSrc       (PCSrc),
        .Result      (Result),
        .kbd_load    (kbd_load),
        .kbd_in      (kbd_in),
        .PC          (PC),
        .PCPlus4     (PCPlus4),
        .PCPlus8     (PCPlus8),
        .imem_we     (imem_we),
        .kbd_code    (kbd_code),
        .fetch_valid (fetch_valid),
        .halted      (halted)
    );

    typedef struct {
        string       name;
        int          tag;
        logic [31:0] pc;
        logic        fv;
        logic        we;
        logic        hl;
        logic [5:0]  kc;
    } exp_t;

    exp_t sb[$];
    int   ncyc     = 0;
    int   checks   = 0;
    int   failures = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Monitor: count negedges, compare every expectation that has fallen due.
    initial begin
        exp_t e;
        #1;
        forever begin
            @(negedge CLK);
            ncyc++;
            while (sb.size() > 0 && sb[0].tag <= ncyc) begin
                e = sb.pop_front();
                checks++;
                if (e.tag != ncyc || PC !== e.pc || PCPlus4 !== e.pc + 32'd4 ||
                    PCPlus8 !== e.pc + 32'd8 || fetch_valid !== e.fv ||
                    imem_we !== e.we || halted !== e.hl || kbd_code !== e.kc) begin
                    failures++;
                    $display("FAIL %s @cyc%0d: got PC=%h P4=%h P8=%h fv=%b we=%b hl=%b kc=%h, want PC=%h fv=%b we=%b hl=%b kc=%h (due cyc%0d)",
                             e.name, ncyc, PC, PCPlus4, PCPlus8, fetch_valid, imem_we,
                             halted, kbd_code, e.pc, e.fv, e.we, e.hl, e.kc, e.tag);
                end
            end
        end
    end

    // Advance to just after the next negedge (monitor has already counted it).
    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    // Expect the given outputs after the coming rising edge, then move there.
    task automatic step(input string name, input logic [31:0] pc, input logic fv,
                        input logic we, input logic hl, input logic [5:0] kc);
        exp_t e;
        e.name = name; e.tag = ncyc + 1; e.pc = pc;
        e.fv = fv; e.we = we; e.hl = hl; e.kc = kc;
        sb.push_back(e);
        tick();
    endtask

    // Short asynchronous reset pulse, entirely between clock edges.
    task automatic rst_pulse();
        RESET = 1'b1;
        #2;
        RESET = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; Stall = 1'b0; PCSrc = 1'b0; Result = 32'h0;
        kbd_load = 1'b0; kbd_in = 6'h0;
        step("reset_state", 32'h0, 1'b0, 1'b0, 1'b0, 6'h00);
        RESET = 1'b0;

        // free run
        step("run1", 32'h4, 1, 0, 0, 6'h00);
        step("run2", 32'h8, 1, 0, 0, 6'h00);

        // stall beats branch, then branch taken
        Stall = 1; PCSrc = 1; Result = 32'h20;
        step("stall_br", 32'h8, 1, 0, 0, 6'h00);
        Stall = 0;
        step("branch", 32'h20, 1, 0, 0, 6'h00);
        Result = 32'hC;
        step("br12", 32'hC, 1, 0, 0, 6'h00);

        // keyboard reload; simultaneous branch is discarded, held level no retrigger
        kbd_in = 6'h2A; kbd_load = 1; Result = 32'h40;
        step("kbd_load", 32'hC, 0, 1, 0, 6'h2A);
        PCSrc = 0;
        step("restart", 32'hC, 0, 0, 0, 6'h2A);
        step("rerun", 32'h0, 1, 0, 0, 6'h2A);
        kbd_load = 0;
        step("run_after", 32'h4, 1, 0, 0, 6'h2A);

        // misaligned branch halts; reload recovers
        PCSrc = 1; Result = 32'h22;
        step("misalign", 32'h4, 0, 0, 1, 6'h2A);
        PCSrc = 0;
        step("halt_hold", 32'h4, 0, 0, 1, 6'h2A);
        kbd_in = 6'h15; kbd_load = 1;
        step("halt_load", 32'h4, 0, 1, 0, 6'h15);
        kbd_load = 0;
        step("halt_restart", 32'h4, 0, 0, 0, 6'h15);
        step("halt_rerun", 32'h0, 1, 0, 0, 6'h15);

        // branch exactly to end of memory halts
        PCSrc = 1; Result = 32'h100;
        step("range_br", 32'h0, 0, 0, 1, 6'h15);
        PCSrc = 0; kbd_in = 6'h01; kbd_load = 1;
        step("range_load", 32'h0, 0, 1, 0, 6'h01);
        kbd_load = 0;
        step("range_restart", 32'h0, 0, 0, 0, 6'h01);
        step("range_rerun", 32'h0, 1, 0, 0, 6'h01);

        // sequential run off the end: 248 -> 252 -> halt at 252
        PCSrc = 1; Result = 32'hF8;
        step("br248", 32'hF8, 1, 0, 0, 6'h01);
        PCSrc = 0;
        step("seq252", 32'hFC, 1, 0, 0, 6'h01);
        step("end_halt", 32'hFC, 0, 0, 1, 6'h01);
        step("end_hold", 32'hFC, 0, 0, 1, 6'h01);

        // reset in the middle of LOAD
        kbd_in = 6'h3F; kbd_load = 1;
        step("ld_for_rst", 32'hFC, 0, 1, 0, 6'h3F);
        kbd_load = 0;
        rst_pulse();
        step("rst_in_load", 32'h4, 1, 0, 0, 6'h00);

        // held kbd_load re-triggers after reset clears the edge detector
        kbd_in = 6'h11; kbd_load = 1;
        step("kbd2", 32'h4, 0, 1, 0, 6'h11);
        rst_pulse();
        step("rst_retrig", 32'h0, 0, 1, 0, 6'h11);
        kbd_load = 0;
        step("retrig_restart", 32'h0, 0, 0, 0, 6'h11);

        for (int i = 0; i < 4 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations never compared, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
